// File: rtl/processor_core_if.sv
// Bus bundle for processor_core: instruction load port, run control and inspection outputs.
// With HALT_INSN_EN defined, a `halted` status line is added.
interface processor_core_if;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        working;
    logic [3:0]  rID;
    logic [31:0] rdata;
    logic [31:0] valE;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [31:0] r4;
    logic [31:0] r5;
    logic [31:0] r6;
    logic [31:0] r7;
    logic [2:0]  cc;
`ifdef HALT_INSN_EN
    logic        halted;

    modport master (
        output addr, wr, wdata, working, rID,
        input  rdata, valE, r0, r1, r2, r3, r4, r5, r6, r7, cc, halted
    );
    modport slave (
        input  addr, wr, wdata, working, rID,
        output rdata, valE, r0, r1, r2, r3, r4, r5, r6, r7, cc, halted
    );
`else
    modport master (
        output addr, wr, wdata, working, rID,
        input  rdata, valE, r0, r1, r2, r3, r4, r5, r6, r7, cc
    );
    modport slave (
        input  addr, wr, wdata, working, rID,
        output rdata, valE, r0, r1, r2, r3, r4, r5, r6, r7, cc
    );
`endif
endinterface

// File: rtl/processor_core.sv
// Single-cycle Y86-style core: irmovl, add/sub/and/xor, nop; one instruction retires per clock.
// Optional HALT_INSN_EN makes icode 0 / ifun 0 a HALT that freezes PC until working drops.
module processor_core #(
    parameter int unsigned IMEM_DEPTH = 256
) (
    input logic             clock,
    input logic             reset,
    processor_core_if.slave bus
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic [31:0]   imem [IMEM_DEPTH];
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   regs_q [8];
    logic [31:0]   regs_d [8];
    logic [31:0]   vale_q, vale_d;
    logic [2:0]    cc_q, cc_d;
`ifdef HALT_INSN_EN
    logic          halted_q, halted_d;
`endif

    logic [31:0] insn;
    logic [3:0]  icode, ifun;
    logic [31:0] va, vb;
    logic [31:0] alu_r;
    logic        alu_of;
    logic        unused_addr;

    assign unused_addr = ^bus.addr[31:AW];

    // Program memory has no reset so it survives a mid-run reset.
    always_ff @(posedge clock) begin
        if (bus.wr && !bus.working) begin
            imem[bus.addr[AW-1:0]] <= bus.wdata;
        end
    end

    assign insn  = imem[pc_q];
    assign icode = insn[31:28];
    assign ifun  = insn[27:24];
    assign va    = insn[23] ? 32'h0 : regs_q[insn[22:20]];
    assign vb    = insn[19] ? 32'h0 : regs_q[insn[18:16]];

    always_comb begin
        alu_r  = 32'h0;
        alu_of = 1'b0;
        case (ifun)
            4'd0: begin
                alu_r  = vb + va;
                alu_of = (va[31] == vb[31]) && (alu_r[31] != vb[31]);
            end
            4'd1: begin
                alu_r  = vb - va;
                alu_of = (va[31] != vb[31]) && (alu_r[31] != vb[31]);
            end
            4'd2:    alu_r = vb & va;
            4'd3:    alu_r = vb ^ va;
            default: ;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        regs_d = regs_q;
        vale_d = vale_q;
        cc_d   = cc_q;
`ifdef HALT_INSN_EN
        halted_d = halted_q;
`endif
        if (!bus.working) begin
            pc_d = '0;
`ifdef HALT_INSN_EN
            halted_d = 1'b0;
        end else if (halted_q) begin
            pc_d = pc_q;
`endif
        end else begin
            pc_d = pc_q + AW'(1);
            case (icode)
                4'h1: begin
                    if (ifun == 4'd0) begin
                        vale_d = {16'h0, insn[15:0]};
                        if (!insn[19]) regs_d[insn[18:16]] = {16'h0, insn[15:0]};
                    end
                end
                4'h2: begin
                    if (ifun < 4'd4) begin
                        vale_d = alu_r;
                        cc_d   = {alu_r == 32'h0, alu_r[31], alu_of};
                        if (!insn[19]) regs_d[insn[18:16]] = alu_r;
                    end
                end
`ifdef HALT_INSN_EN
                4'h0: begin
                    if (ifun == 4'd0) begin
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q   <= '0;
            vale_q <= 32'h0;
            cc_q   <= 3'b000;
            for (int i = 0; i < 8; i++) regs_q[i] <= 32'h0;
`ifdef HALT_INSN_EN
            halted_q <= 1'b0;
`endif
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            vale_q <= vale_d;
            cc_q   <= cc_d;
`ifdef HALT_INSN_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign bus.valE  = vale_q;
    assign bus.cc    = cc_q;
    assign bus.r0    = regs_q[0];
    assign bus.r1    = regs_q[1];
    assign bus.r2    = regs_q[2];
    assign bus.r3    = regs_q[3];
    assign bus.r4    = regs_q[4];
    assign bus.r5    = regs_q[5];
    assign bus.r6    = regs_q[6];
    assign bus.r7    = regs_q[7];
    assign bus.rdata = bus.rID[3] ? 32'h0 : regs_q[bus.rID[2:0]];
`ifdef HALT_INSN_EN
    assign bus.halted = halted_q;
`endif

endmodule

// File: tb/tb_processor_core.sv
// Self-checking bench for processor_core: directed test-plan programs plus random programs,
// compared against an instruction-level reference model.
module tb_processor_core;
    logic clk = 1'b0;
    logic rst;
    processor_core_if bus ();

    processor_core #(.IMEM_DEPTH(256)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dut_r [8];
    assign dut_r[0] = bus.r0;
    assign dut_r[1] = bus.r1;
    assign dut_r[2] = bus.r2;
    assign dut_r[3] = bus.r3;
    assign dut_r[4] = bus.r4;
    assign dut_r[5] = bus.r5;
    assign dut_r[6] = bus.r6;
    assign dut_r[7] = bus.r7;

    // Reference model state
    logic [31:0] m_imem [256];
    logic [31:0] m_regs [8];
    logic [31:0] m_vale;
    logic [2:0]  m_cc;

    function automatic logic [31:0] rd(input logic [3:0] id);
        return (id < 4'd8) ? m_regs[id[2:0]] : 32'h0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
        m_vale = 32'h0;
        m_cc   = 3'b000;
    endfunction

    // Overflow is judged by comparing the exact signed result with the wrapped 32-bit one.
    function automatic void exec(input logic [31:0] w);
        logic [3:0]  ic = w[31:28];
        logic [3:0]  fn = w[27:24];
        logic [31:0] a  = rd(w[23:20]);
        logic [31:0] b  = rd(w[19:16]);
        logic [31:0] r  = 32'h0;
        longint      s  = 0;
        logic        ov = 1'b0;
        if (ic == 4'h1 && fn == 4'h0) begin
            m_vale = {16'h0, w[15:0]};
            if (w[19:16] < 4'd8) m_regs[w[18:16]] = m_vale;
        end else if (ic == 4'h2 && fn < 4'h4) begin
            case (fn)
                4'h0: begin
                    r  = b + a;
                    s  = longint'($signed(b)) + longint'($signed(a));
                    ov = (s != longint'($signed(r)));
                end
                4'h1: begin
                    r  = b - a;
                    s  = longint'($signed(b)) - longint'($signed(a));
                    ov = (s != longint'($signed(r)));
                end
                4'h2:    r = b & a;
                default: r = b ^ a;
            endcase
            m_vale = r;
            m_cc   = {r == 32'h0, r[31], ov};
            if (w[19:16] < 4'd8) m_regs[w[18:16]] = r;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic compare_state(input string tag);
        check({tag, "_valE"}, bus.valE, m_vale);
        check({tag, "_cc"}, {29'h0, bus.cc}, {29'h0, m_cc});
        for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), dut_r[i], m_regs[i]);
    endtask

    task automatic load_word(input int a, input logic [31:0] w);
        bus.addr  = a;
        bus.wdata = w;
        bus.wr    = 1'b1;
        @(posedge clk);
        #1 bus.wr = 1'b0;
        m_imem[a[7:0]] = w;
    endtask

    // Runs imem[0..n-1] from PC 0, then idles one edge so PC returns to 0.
    task automatic run_prog(input int n);
        bus.working = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.working = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) exec(m_imem[i]);
    endtask

    function automatic logic [31:0] rand_word();
        int unsigned sel = $urandom_range(0, 9);
        logic [3:0]  ra  = 4'($urandom_range(0, 9));
        logic [3:0]  rb  = 4'($urandom_range(0, 9));
        logic [15:0] vc  = 16'($urandom);
        if (sel < 4) return {4'h1, 4'h0, ra, rb, vc};
        if (sel < 8) return {4'h2, 4'($urandom_range(0, 5)), ra, rb, vc};
        if (sel == 8) return {4'h1, 4'($urandom_range(1, 15)), ra, rb, vc};
        return {4'($urandom_range(3, 15)), 4'($urandom_range(1, 15)), ra, rb, vc};
    endfunction

    logic [31:0] prog_q [$];

    initial begin
        rst         = 1'b1;
        bus.addr    = 32'h0;
        bus.wr      = 1'b0;
        bus.wdata   = 32'h0;
        bus.working = 1'b0;
        bus.rID     = 4'd0;
        m_reset();
        #12;
        compare_state("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Test plan: irmovl r0..r7 = 0x80..0x87
        for (int i = 0; i < 8; i++) load_word(i, 32'h10F00080 | (i << 16) | i);
        run_prog(8);
        compare_state("irmov");
        for (int i = 0; i < 8; i++) check($sformatf("tp_r%0d", i), dut_r[i], 32'h80 + i);
        check("tp_valE_87", bus.valE, 32'h87);

        load_word(8, 32'h20010000);
        run_prog(9);
        compare_state("add");
        check("tp_add_r1", bus.r1, 32'h101);

        load_word(9, 32'h11000000);
        load_word(10, 32'h21230000);
        load_word(11, 32'h12000000);
        load_word(12, 32'h22450000);
        load_word(13, 32'h23670000);
        run_prog(14);
        compare_state("alu");
        check("tp_sub_r3", bus.r3, 32'h1);
        check("tp_and_r5", bus.r5, 32'h84);
        check("tp_xor_r7", bus.r7, 32'h1);
        check("tp_alu_cc", {29'h0, bus.cc}, 32'h0);

        // Writes while running must be ignored
        bus.working = 1'b1;
        bus.wr      = 1'b1;
        bus.addr    = 32'h0;
        bus.wdata   = 32'h10F0DEAD;
        repeat (14) @(posedge clk);
        #1 bus.wr = 1'b0;
        bus.working = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) exec(m_imem[i]);
        run_prog(14);
        compare_state("wr_run");
        check("wr_run_r0", bus.r0, 32'h80);

        // Reset mid-run, then rerun with working still high
        bus.working = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 m_reset();
        compare_state("midreset");
        @(negedge clk) rst = 1'b0;
        repeat (14) @(posedge clk);
        #1 bus.working = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) exec(m_imem[i]);
        compare_state("rerun");
        check("rerun_r1", bus.r1, 32'h101);
        check("rerun_r7", bus.r7, 32'h1);

        for (int id = 0; id < 16; id++) begin
            bus.rID = 4'(id);
            #1 check($sformatf("rdata_id%0d", id), bus.rdata, rd(4'(id)));
        end

        // Zero result: 5 - 5
        load_word(0, 32'h10F00005);
        load_word(1, 32'h10F10005);
        load_word(2, 32'h21010000);
        run_prog(3);
        compare_state("zero");
        check("zero_r1", bus.r1, 32'h0);
        check("zero_cc", {29'h0, bus.cc}, 32'h4);

        // Signed overflow: 0x7FFFFFFF + 1
        prog_q = {32'h10F28000};
        repeat (16) prog_q.push_back(32'h20220000);
        prog_q.push_back(32'h10F30001);
        prog_q.push_back(32'h21320000);
        prog_q.push_back(32'h10F10000);
        prog_q.push_back(32'h20210000);
        prog_q.push_back(32'h10F00001);
        prog_q.push_back(32'h20010000);
        for (int i = 0; i < prog_q.size(); i++) load_word(i, prog_q[i]);
        run_prog(prog_q.size());
        compare_state("ovf");
        check("ovf_r1", bus.r1, 32'h80000000);
        check("ovf_cc", {29'h0, bus.cc}, 32'h3);

        // Random programs
        for (int it = 0; it < 8; it++) begin
            int n = $urandom_range(8, 48);
            for (int i = 0; i < n; i++) load_word(i, rand_word());
            run_prog(n);
            compare_state($sformatf("rand%0d", it));
            bus.rID = 4'($urandom_range(0, 15));
            #1 check($sformatf("rand%0d_rdata", it), bus.rdata, rd(bus.rID));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/processor_core.md
Name: processor_core

Overview:
- Minimal Y86-style sequential processor for EX-stage bring-up.
- Instruction memory is loaded over a simple write port while idle, then run when `working` is high.
- Executes one instruction per clock: immediate-move, ALU ops (add/sub/and/xor) and nop.
- Exposes all eight registers, the ALU result, condition codes and a register read-back port for bench inspection.

Parameters:
- IMEM_DEPTH, 256, instruction words; PC and `addr` index use the low log2(IMEM_DEPTH) bits.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  instruction-memory write address (word index).
- wr  in  1  write strobe for instruction memory.
- wdata  in  32  instruction word to write.
- working  in  1  1 = execute program; 0 = idle/load mode.
- rID  in  4  register read-back select.
- valE  out  32  result of last executed ALU/irmov instruction (registered).
- r0..r7  out  32 each  live register file contents.
- rdata  out  32  regfile[rID] when rID<8, else 0 (combinational).
- cc  out  3  condition codes {ZF,SF,OF} = cc[2],cc[1],cc[0].

Behaviour:
- Reset (async, active-high): PC=0, r0..r7=0, valE=0, cc=0. Instruction memory is not cleared.
- Instruction format: icode=[31:28], ifun=[27:24], rA=[23:20], rB=[19:16], valC=[15:0]. Register ids 0-7 are valid; 8-15 mean "none" (read as 0, writes discarded).
- Load mode (working=0):
  - On posedge with wr=1: imem[addr] <= wdata.
  - PC held at 0. Registers, cc and valE hold.
- Run mode (working=1):
  - wr is ignored.
  - Each posedge: fetch imem[PC], execute, write back, and set PC <= PC+1 (wraps modulo IMEM_DEPTH).
  - One instruction retires per cycle, so there are no hazards; inserted nops are harmless.
- Dropping working returns PC to 0 on the next edge. State (registers, cc, valE) is retained.
- icode 1, ifun 0 (irmovl):
  - rB <= zero-extended valC; valE <= same.
  - cc unchanged.
- icode 1, ifun != 0: nop.
- icode 2 (OPl), result R written to rB, valE <= R:
  - ifun 0: R = rB + rA.
  - ifun 1: R = rB - rA.
  - ifun 2: R = rB & rA.
  - ifun 3: R = rB ^ rA.
  - ifun 4-15: nop, cc unchanged.
- Condition codes (icode 2, ifun 0-3 only): ZF = (R==0); SF = R[31]; OF as follows:
  - add: operands have the same sign and R's sign differs.
  - sub: signs of rB and rA differ and R's sign differs from rB.
  - and/xor: OF = 0.
- All other icodes, including 0x00000000, are nop: no register, cc or valE change.
- Arithmetic is 32-bit modulo; no exceptions.
- rID/rdata are combinational and usable in any mode.
- Reset asserted mid-run aborts immediately; the program reruns from PC 0 after release if working is still 1.

Optional Feature:
- Macro: HALT_INSN_EN.
- Defined:
  - icode 0 ifun 0 is HALT. PC freezes at the HALT address with no state change until working drops.
  - A status output `halted` (1 bit) is high while frozen; it clears when working=0 or on reset.
- Undefined: icode 0 is an ordinary nop, PC keeps incrementing, and there is no `halted` port.

Test Plan:
- Load irmovl r0..r7 = 0x80..0x87 (words 0x10F00080..0x10F70087), run 8 cycles -> r0..r7 = 0x80..0x87, valE = 0x87, cc = 0.
- Append 0x20010000 (add r0,r1) -> r1 = 0x101, valE = 0x101, cc = 000.
- Append 0x21230000 (sub) -> r3 = 0x83-0x82 = 1; then 0x22450000 (and) -> r5 = 0x84; then 0x23670000 (xor) -> r7 = 1. Nops 0x11000000 / 0x12000000 in between change nothing; final cc = 000.
- Edge cases:
  - r0 = 5, r1 = 5, sub r0,r1 -> r1 = 0, cc = 100.
  - r0 = 1, r1 = 0x7FFFFFFF, add -> r1 = 0x80000000, cc = 011.
- Write with wr=1 while working=1 -> imem unchanged. Hold working=0 and sweep rID 0..15 -> rdata = r0..r7, then 0 for rID 8..15.
- Assert reset mid-run -> PC, r0..r7, valE and cc go to 0 asynchronously. Program memory survives, and rerunning reproduces the results above.
